// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter.
//   - legal ranges for DATA_W and STOP_BITS
//   - serialiser FSM state encoding
// Optional feature macro: UART_TX_PARITY_EN adds the StParity state.
package uart_pkg;

  localparam int unsigned DataWMin    = 5;
  localparam int unsigned DataWMax    = 8;
  localparam int unsigned StopBitsMin = 1;
  localparam int unsigned StopBitsMax = 2;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} uart_state_e;
`else
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop} uart_state_e;
`endif

endpackage

// File: rtl/sync_fifo.sv
// Synchronous single-clock FIFO with show-ahead read data.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   wr_valid_i/_data  write request; accepted when wr_ready_o is high
//   wr_ready_o        not full
//   rd_en_i           pop request; ignored when empty
//   rd_data_o         entry at the head (valid while level_o != 0)
//   level_o           occupancy, 0..Depth
module sync_fifo #(
  parameter int unsigned Depth = 16,
  parameter int unsigned DataW = 8,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned LvlW = PtrW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_valid_i,
  input  logic [DataW-1:0] wr_data_i,
  output logic             wr_ready_o,
  input  logic             rd_en_i,
  output logic [DataW-1:0] rd_data_o,
  output logic [LvlW-1:0]  level_o
);

  logic [DataW-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]  level_q;
  logic             do_wr, do_rd;

  // Full blocks writes even when a pop happens on the same edge.
  assign wr_ready_o = (level_q != LvlW'(Depth));
  assign do_wr      = wr_valid_i & wr_ready_o;
  assign do_rd      = rd_en_i & (level_q != '0);
  assign rd_data_o  = mem_q[rd_ptr_q];
  assign level_o    = level_q;

  always_ff @(posedge clk_i) begin
    if (do_wr && !rst_i) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  // Pointers wrap naturally since Depth is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (do_wr && !do_rd) begin
        level_q <= level_q + LvlW'(1);
      end else if (!do_wr && do_rd) begin
        level_q <= level_q - LvlW'(1);
      end
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: a sync_fifo feeding a serialiser FSM.
// Frame: start bit (0), DATA_W data bits LSB first, optional parity, STOP_BITS
// high bits. Each bit lasts max(div,1) clocks; div is captured when a frame starts.
// Optional feature macro: UART_TX_PARITY_EN adds input parity_odd (0 = even,
// 1 = odd parity), captured together with div.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   div               clocks per bit
//   wr_valid/wr_data  byte to enqueue; wr_ready = not full
//   uart_tx           serial line, idle high
//   tx_send/tx_data   one-cycle pulse and byte of each starting frame
//   busy              frame on the line
//   level             FIFO occupancy
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned DIV_W     = 16,
  parameter int unsigned STOP_BITS = 1,
  localparam int unsigned LvlW = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DIV_W-1:0]  div,
`ifdef UART_TX_PARITY_EN
  input  logic              parity_odd,
`endif
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              uart_tx,
  output logic              tx_send,
  output logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic [LvlW-1:0]   level
);

  localparam int unsigned BitW = $clog2(DATA_W);

  if (DATA_W < DataWMin || DATA_W > DataWMax ||
      STOP_BITS < StopBitsMin || STOP_BITS > StopBitsMax) begin : gen_param_err
    $error("uart_tx_fifo: DATA_W or STOP_BITS out of range");
  end

  uart_state_e       state_q;
  logic [DIV_W-1:0]  cnt_q, div_q, eff_div;
  logic [BitW-1:0]   bit_q;
  logic              stop_q;
  logic [DATA_W-1:0] sh_q, rd_data;
  logic              bit_done, frame_done, pop;
`ifdef UART_TX_PARITY_EN
  logic              par_q;
`endif

  sync_fifo #(
    .Depth (DEPTH),
    .DataW (DATA_W)
  ) u_fifo (
    .clk_i      (clk),
    .rst_i      (rst),
    .wr_valid_i (wr_valid),
    .wr_data_i  (wr_data),
    .wr_ready_o (wr_ready),
    .rd_en_i    (pop),
    .rd_data_o  (rd_data),
    .level_o    (level)
  );

  assign eff_div    = (div == '0) ? DIV_W'(1) : div;
  assign bit_done   = (cnt_q == div_q - DIV_W'(1));
  assign frame_done = (state_q == StStop) && bit_done && (stop_q == 1'(STOP_BITS - 1));
  // Popping at the end of the last stop bit gives back-to-back frames.
  assign pop        = (level != '0) && ((state_q == StIdle) || frame_done);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      uart_tx <= 1'b1;
      tx_send <= 1'b0;
      tx_data <= '0;
      busy    <= 1'b0;
      cnt_q   <= '0;
      div_q   <= DIV_W'(1);
      bit_q   <= '0;
      stop_q  <= 1'b0;
      sh_q    <= '0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      tx_send <= 1'b0;
      if (pop) begin
        state_q <= StStart;
        uart_tx <= 1'b0;
        tx_send <= 1'b1;
        tx_data <= rd_data;
        busy    <= 1'b1;
        sh_q    <= rd_data;
        div_q   <= eff_div;
        cnt_q   <= '0;
        bit_q   <= '0;
        stop_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
        par_q   <= (^rd_data) ^ parity_odd;
`endif
      end else begin
        case (state_q)
          StIdle: ;
          StStart: begin
            if (bit_done) begin
              state_q <= StData;
              uart_tx <= sh_q[0];
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + DIV_W'(1);
            end
          end
          StData: begin
            if (bit_done) begin
              cnt_q <= '0;
              if (bit_q == BitW'(DATA_W - 1)) begin
`ifdef UART_TX_PARITY_EN
                state_q <= StParity;
                uart_tx <= par_q;
`else
                state_q <= StStop;
                uart_tx <= 1'b1;
`endif
              end else begin
                // sh_q[1] is the next data bit before the shift lands.
                bit_q   <= bit_q + BitW'(1);
                sh_q    <= sh_q >> 1;
                uart_tx <= sh_q[1];
              end
            end else begin
              cnt_q <= cnt_q + DIV_W'(1);
            end
          end
`ifdef UART_TX_PARITY_EN
          StParity: begin
            if (bit_done) begin
              state_q <= StStop;
              uart_tx <= 1'b1;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + DIV_W'(1);
            end
          end
`endif
          StStop: begin
            if (bit_done) begin
              cnt_q <= '0;
              if (frame_done) begin
                state_q <= StIdle;
                busy    <= 1'b0;
              end else begin
                stop_q <= 1'b1;
              end
            end else begin
              cnt_q <= cnt_q + DIV_W'(1);
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: writes push expected frames into a queue,
// a monitor pops one per tx_send and checks tx_data plus every line cycle.
// A second instance with STOP_BITS=2 is checked cycle by cycle inline.
module tb_uart_tx_fifo;

`ifdef UART_TX_PARITY_EN
  localparam int Par = 1;
`else
  localparam int Par = 0;
`endif

  typedef struct packed {
    logic [7:0]  data;
    logic [15:0] d;
    logic        odd;
  } exp_t;

  logic        clk, rst, parity_odd;
  logic [15:0] div, b_div;
  logic        wr_valid, b_wr_valid;
  logic [7:0]  wr_data, b_wr_data;
  logic        wr_ready, uart_tx, tx_send, busy;
  logic [7:0]  tx_data;
  logic [2:0]  level;
  logic        b_wr_ready, b_uart_tx, b_tx_send, b_busy;
  logic [7:0]  b_tx_data;
  logic [2:0]  b_level;

  int   checks = 0, failures = 0, cyc = 0, sends = 0, b2b = 0, last_end = -10;
  bit   mon_en = 0, mon_abort = 0;
  exp_t sb_q[$];

  uart_tx_fifo #(.DATA_W(8), .DEPTH(4), .DIV_W(16), .STOP_BITS(1)) u_dut (
    .clk(clk), .rst(rst), .div(div),
`ifdef UART_TX_PARITY_EN
    .parity_odd(parity_odd),
`endif
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready), .uart_tx(uart_tx),
    .tx_send(tx_send), .tx_data(tx_data), .busy(busy), .level(level)
  );

  uart_tx_fifo #(.DATA_W(8), .DEPTH(4), .DIV_W(16), .STOP_BITS(2)) u_dut_b (
    .clk(clk), .rst(rst), .div(b_div),
`ifdef UART_TX_PARITY_EN
    .parity_odd(parity_odd),
`endif
    .wr_valid(b_wr_valid), .wr_data(b_wr_data), .wr_ready(b_wr_ready), .uart_tx(b_uart_tx),
    .tx_send(b_tx_send), .tx_data(b_tx_data), .busy(b_busy), .level(b_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Line value for bit slot idx of a frame: start, 8 data, [parity], stop(s).
  function automatic logic exp_bit(input logic [7:0] d, input logic odd, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if (Par == 1 && idx == 9) return (^d) ^ odd;
    return 1'b1;
  endfunction

  // Drive one write at the current negedge; caller knows wr_ready is high.
  task automatic push_write(input logic [7:0] d);
    exp_t e;
    wr_valid = 1'b1;
    wr_data  = d;
    e.data = d;
    e.d    = (div == 16'd0) ? 16'd1 : div;
    e.odd  = parity_odd;
    sb_q.push_back(e);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((sb_q.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_in_budget", n < budget, 1);
  endtask

  task automatic wait_send(input int budget);
    int n = 0;
    while (!tx_send && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("send_in_budget", n < budget, 1);
  endtask

  // Monitor / scoreboard for u_dut.
  initial begin : monitor
    exp_t e;
    bit   aborted;
    forever begin
      @(negedge clk);
      if (!mon_en || mon_abort) continue;
      if (!tx_send) begin
        chk("idle_line", uart_tx, 1);
        chk("idle_busy", busy, 0);
        continue;
      end
      sends++;
      chk("sb_has_entry", sb_q.size() != 0, 1);
      if (sb_q.size() == 0) continue;
      e = sb_q.pop_front();
      chk("tx_data", tx_data, e.data);
      if (last_end + 1 == cyc) b2b++;
      aborted = 0;
      for (int b = 0; b < 10 + Par; b++) begin
        for (int c = 0; c < int'(e.d); c++) begin
          if (b != 0 || c != 0) begin
            @(negedge clk);
            if (mon_abort) aborted = 1;
          end
          if (aborted) break;
          chk("frame_line", uart_tx, exp_bit(e.data, e.odd, b));
          chk("frame_busy", busy, 1);
          if (b != 0 || c != 0) chk("frame_no_send", tx_send, 0);
        end
        if (aborted) break;
      end
      last_end = cyc;
    end
  end

  initial begin : stimulus
    logic [7:0] bytes6 [6];
    int s0, b0, n, t0, seen;
    bit saw_full;
    bytes6 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    rst = 1'b1; parity_odd = 1'b0; div = 16'd4; b_div = 16'd3;
    wr_valid = 1'b0; wr_data = 8'h00; b_wr_valid = 1'b0; b_wr_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_uart_tx", uart_tx, 1);
    chk("rst_tx_send", tx_send, 0);
    chk("rst_busy", busy, 0);
    chk("rst_level", level, 0);
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_tx_data", tx_data, 0);
    rst = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;

    // div=4, single byte 0x55, start bit on second edge after the write.
    s0 = sends;
    push_write(8'h55);
    @(negedge clk);
    wr_valid = 1'b0;
    chk("lat_edge1_line", uart_tx, 1);
    chk("lat_edge1_level", level, 1);
    @(negedge clk);
    chk("lat_edge2_send", tx_send, 1);
    chk("lat_edge2_line", uart_tx, 0);
    drain(200);
    chk("x55_one_pulse", sends - s0, 1);

    // div=0 acts as 1: frame is 10 (+parity) cycles long.
    div = 16'd0;
    push_write(8'hC3);
    @(negedge clk);
    wr_valid = 1'b0;
    wait_send(10);
    t0 = cyc;
    n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("div0_frame_len", cyc - t0, 10 + Par);
    drain(50);

    // div=8, 6 back-to-back writes into a 4-deep FIFO.
    div = 16'd8;
    s0 = sends; b0 = b2b; saw_full = 0;
    for (int i = 0; i < 6; i++) begin
      wr_valid = 1'b1;
      wr_data  = bytes6[i];
      n = 0;
      while (!wr_ready && n < 200) begin
        if (!saw_full) begin
          saw_full = 1;
          chk("full_level", level, 4);
          chk("full_write_index", i, 5);
        end
        @(negedge clk);
        n++;
      end
      chk("write_accepted", n < 200, 1);
      push_write(bytes6[i]);
      @(negedge clk);
    end
    wr_valid = 1'b0;
    drain(1000);
    chk("full_seen", saw_full, 1);
    chk("six_sent", sends - s0, 6);
    chk("no_gap_frames", b2b - b0, 5);

    // Reset mid data bit with three bytes still queued.
    for (int i = 0; i < 4; i++) begin
      push_write(8'h81 + 8'(i));
      @(negedge clk);
    end
    wr_valid = 1'b0;
    repeat (20) @(negedge clk);
    chk("pre_rst_level", level, 3);
    chk("pre_rst_busy", busy, 1);
    mon_abort = 1'b1;
    rst = 1'b1;
    wr_valid = 1'b1;
    wr_data = 8'hEE;
    @(negedge clk);
    chk("arst_line", uart_tx, 1);
    chk("arst_busy", busy, 0);
    chk("arst_level", level, 0);
    chk("arst_send", tx_send, 0);
    chk("arst_wr_ready", wr_ready, 1);
    @(negedge clk);
    chk("arst_wr_ignored", level, 0);
    rst = 1'b0;
    wr_valid = 1'b0;
    sb_q.delete();
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (tx_send) seen++;
    end
    chk("no_send_after_rst", seen, 0);
    chk("post_rst_line", uart_tx, 1);
    mon_abort = 1'b0;

`ifdef UART_TX_PARITY_EN
    // 0x07 has three ones: even parity bit 1, odd parity bit 0.
    div = 16'd2;
    for (int k = 0; k < 2; k++) begin
      parity_odd = k[0];
      push_write(8'h07);
      @(negedge clk);
      wr_valid = 1'b0;
      wait_send(10);
      repeat (18) @(negedge clk);
      chk(k == 0 ? "parity_even_bit" : "parity_odd_bit", uart_tx, k == 0 ? 1 : 0);
      drain(100);
    end
`endif

    // STOP_BITS=2, div=3: two frames, 6 high stop cycles then next start.
    b_wr_valid = 1'b1;
    b_wr_data = 8'hA5;
    @(negedge clk);
    b_wr_data = 8'h3C;
    @(negedge clk);
    b_wr_valid = 1'b0;
    n = 0;
    while (!b_tx_send && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("b_send_in_budget", n < 10, 1);
    chk("b_tx_data0", b_tx_data, 8'hA5);
    for (int f = 0; f < 2; f++) begin
      for (int b = 0; b < 11 + Par; b++) begin
        for (int c = 0; c < 3; c++) begin
          if (f != 0 || b != 0 || c != 0) @(negedge clk);
          if (f == 1 && b == 0 && c == 0) begin
            chk("b_b2b_send", b_tx_send, 1);
            chk("b_tx_data1", b_tx_data, 8'h3C);
          end
          chk("b_line", b_uart_tx, exp_bit(f == 0 ? 8'hA5 : 8'h3C, parity_odd, b));
        end
      end
    end
    @(negedge clk);
    chk("b_idle_line", b_uart_tx, 1);
    chk("b_idle_busy", b_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
